// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_SWITCH = 3'd2
    } state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_ADVANCE = '{
        pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
        id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1
    };
    localparam pipe_ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect #(
    parameter int unsigned REG_ADDR_W = pipeline_ctrl_pkg::REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    output logic                  lu
);
    import pipeline_ctrl_pkg::*;

    // x0 is hardwired to zero, so a load targeting it never creates a hazard
    assign lu = ex_mem_read && (ex_rd != REG_ADDR_W'(X0)) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                 (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazards, cache waits and
// the drain/handshake ahead of a cache switch.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W   = pipeline_ctrl_pkg::REG_ADDR_W,
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  imem_busy,
    input  logic                  dmem_busy,
    input  logic                  cs_req,
    input  logic                  cs_done,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  if_id_flush,
    output logic                  id_ex_en,
    output logic                  id_ex_flush,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  cs_ack,
    output logic [2:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);
    import pipeline_ctrl_pkg::*;

    localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_e             state_q, state_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               cs_ack_q;
    logic               lu;
    logic               stall_ev, flush_ev;
    pipe_ctrl_t         ctrl;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (lu)
    );

    // Next state and stage controls; priority dmem_busy > redirect > load-use > imem_busy
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        ctrl     = CTRL_FREEZE;
        stall_ev = 1'b0;
        flush_ev = 1'b0;

        case (state_q)
            ST_RUN, ST_DRAIN: begin
                ctrl = CTRL_ADVANCE;
                if (state_q == ST_DRAIN) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.if_id_flush = 1'b1;
                end
                if (dmem_busy) begin
                    ctrl = CTRL_FREEZE;
                end else if (ex_redirect) begin
                    ctrl.pc_en       = 1'b1;
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    flush_ev         = 1'b1;
                end else if (lu) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.if_id_en    = 1'b0;
                    ctrl.if_id_flush = 1'b0;
                    ctrl.id_ex_flush = 1'b1;
                    stall_ev         = 1'b1;
                end else if (imem_busy) begin
                    ctrl.pc_en       = 1'b0;
                    ctrl.if_id_flush = 1'b1;
                    stall_ev         = 1'b1;
                end

                if (state_q == ST_RUN) begin
                    if (cs_req && !dmem_busy) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end else if (!dmem_busy) begin
                    if (!cs_req) begin
                        state_d = ST_RUN;
                        drain_d = '0;
                    end else if (!(lu && !ex_redirect)) begin
                        if (drain_q == DRAIN_LAST) begin
                            state_d = ST_SWITCH;
                            drain_d = '0;
                        end else begin
                            drain_d = drain_q + DRAIN_W'(1);
                        end
                    end
                end
            end
            ST_SWITCH: begin
                if (cs_done) state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase

        if (!reset) ctrl = CTRL_FREEZE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            drain_q  <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            cs_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            cs_ack_q <= (state_d == ST_SWITCH);
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (flush_ev && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign if_id_en    = ctrl.if_id_en;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_en    = ctrl.id_ex_en;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign ex_mem_en   = ctrl.ex_mem_en;
    assign mem_wb_en   = ctrl.mem_wb_en;
    assign cs_ack      = cs_ack_q;
    assign state_o     = 3'(state_q);
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cases then random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned DC = 4;
    localparam int unsigned CW = 32;
    localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

    typedef struct packed {
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic [RW-1:0] rd;
        logic u1, u2, mr, redir, imem, dmem, req, done;
    } stim_t;

    typedef struct packed {
        logic [6:0]    ctl;
        logic          ack;
        logic [2:0]    st;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
    logic imem_busy, dmem_busy, cs_req, cs_done;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic cs_ack;
    logic [2:0] state_o;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
        .imem_busy(imem_busy), .dmem_busy(dmem_busy), .cs_req(cs_req), .cs_done(cs_done),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
        .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .cs_ack(cs_ack), .state_o(state_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_run = 0;
    int n_fail = 0;
    exp_t sb[$];

    // Reference model: mode 0=running, 1=draining, 2=waiting for switch
    int m_mode = 0;
    int m_done_cycles = 0;
    longint unsigned m_stall = 0;
    longint unsigned m_flush = 0;
    bit m_ack = 1'b0;

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        n_run++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_mem_read = s.mr;
        ex_redirect = s.redir; imem_busy = s.imem; dmem_busy = s.dmem;
        cs_req = s.req; cs_done = s.done;
    endtask

    // One clock of stimulus: drive, predict this cycle's outputs, advance the model
    task automatic step(input stim_t s);
        bit hz;
        bit drn;
        exp_t e;
        @(posedge clk);
        #1;
        drive(s);
        hz  = s.mr && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        drn = (m_mode == 1);
        e.ack   = m_ack;
        e.st    = 3'(m_mode);
        e.stall = CW'(m_stall);
        e.flush = CW'(m_flush);
        if (m_mode == 2 || s.dmem) e.ctl = '0;
        else e.ctl = {s.redir || !(hz || s.imem || drn),
                      s.redir || !hz,
                      s.redir || (!hz && (s.imem || drn)),
                      1'b1,
                      s.redir || hz,
                      1'b1, 1'b1};
        sb.push_back(e);

        if (m_mode != 2 && !s.dmem) begin
            if (s.redir) m_flush = (m_flush < CMAX) ? m_flush + 1 : m_flush;
            else if (hz || s.imem) m_stall = (m_stall < CMAX) ? m_stall + 1 : m_stall;
        end
        case (m_mode)
            0: if (s.req && !s.dmem) begin m_mode = 1; m_done_cycles = 0; end
            1: if (!s.dmem) begin
                   if (!s.req) m_mode = 0;
                   else if (!(hz && !s.redir)) begin
                       m_done_cycles++;
                       if (m_done_cycles == DC) m_mode = 2;
                   end
               end
            default: if (s.done) m_mode = 0;
        endcase
        m_ack = (m_mode == 2);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}, 0);
        chk({tag, "_state"}, state_o, 0);
        chk({tag, "_ack"}, cs_ack, 0);
        chk({tag, "_cnts"}, {stall_cnt, flush_cnt}, 0);
    endtask

    task automatic async_reset(input string tag);
        for (int i = 0; i < 4 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
        drive(idle());
        reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        m_mode = 0; m_done_cycles = 0; m_stall = 0; m_flush = 0; m_ack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stage_ctl", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}, e.ctl);
                chk("state_o", state_o, e.st);
                chk("cs_ack", cs_ack, e.ack);
                chk("stall_cnt", stall_cnt, e.stall);
                chk("flush_cnt", flush_cnt, e.flush);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        bit req_hold;
        reset = 1'b0;
        drive(idle());
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Load-use on rs1, then normal flow
        s = idle(); s.mr = 1; s.rd = 5; s.u1 = 1; s.rs1 = 5;
        step(s); step(idle());
        // Load to x0 never stalls
        s = idle(); s.mr = 1; s.rd = 0; s.u1 = 1; s.rs1 = 0;
        step(s); step(idle());
        // Redirect wins over load-use
        s = idle(); s.mr = 1; s.rd = 7; s.u2 = 1; s.rs2 = 7; s.redir = 1;
        step(s);
        // dmem freeze over a load-use, then the stall
        s = idle(); s.mr = 1; s.rd = 3; s.u1 = 1; s.rs1 = 3; s.dmem = 1;
        repeat (3) step(s);
        s.dmem = 0;
        step(s); step(idle());
        imem_check: begin
            s = idle(); s.imem = 1;
            step(s);
        end

        // Cache switch with one dmem wait inside the drain
        s = idle(); s.req = 1;
        step(s); step(s);
        s.dmem = 1; step(s);
        s.dmem = 0; repeat (3) step(s);
        step(s);
        s.done = 1; step(s);
        step(idle());

        // Abort drain by dropping cs_req
        s = idle(); s.req = 1;
        step(s); step(s); step(s);
        step(idle()); step(idle());

        // Async reset while in SWITCH
        s = idle(); s.req = 1;
        for (int i = 0; i < 20 && m_mode != 2; i++) step(s);
        step(s);
        async_reset("reset_in_switch");

        // Randomized traffic
        req_hold = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            s.rs1   = RW'($urandom_range(0, 3));
            s.rs2   = RW'($urandom_range(0, 3));
            s.rd    = RW'($urandom_range(0, 3));
            s.u1    = ($urandom_range(0, 99) < 70);
            s.u2    = ($urandom_range(0, 99) < 50);
            s.mr    = ($urandom_range(0, 99) < 35);
            s.redir = ($urandom_range(0, 99) < 12);
            s.imem  = ($urandom_range(0, 99) < 15);
            s.dmem  = ($urandom_range(0, 99) < 12);
            if (m_mode == 2) req_hold = ($urandom_range(0, 1) == 1);
            else if (req_hold) req_hold = ($urandom_range(0, 99) < 96);
            else req_hold = ($urandom_range(0, 99) < 8);
            s.req  = req_hold;
            s.done = (m_mode == 2) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 3);
            step(s);
        end
        async_reset("final_reset");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Drives enable and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves load-use hazards, branch/jump redirects and instruction/data memory (cache) wait states.
- Sequences the pipeline drain and handshake needed before an OS-context-driven cache switch.

Parameters:
REG_ADDR_W, 5, register index width
DRAIN_CYCLES, 4, advancing cycles needed to retire ID..WB after fetch stops (minimum 1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset (low = reset)
id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  branch taken or jump resolved in EX
imem_busy  in  1  instruction cache not ready
dmem_busy  in  1  data cache not ready
cs_req  in  1  cache-switch request, level, held until cs_ack
cs_done  in  1  one-cycle pulse: cache switch complete
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID load bubble
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX load bubble
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
cs_ack  out  1  pipeline drained, held in SWITCH
state_o  out  3  current FSM state
stall_cnt  out  CNT_W  cycles ID held by hazard/imem
flush_cnt  out  CNT_W  redirect flushes

Behaviour:
- Storage: state, drain counter, both perf counters, cs_ack. All are reset asynchronously on reset low.
  - Reset values: state=RUN, drain counter=0, stall_cnt=0, flush_cnt=0, cs_ack=0.
- Outputs other than cs_ack are combinational from state and inputs.
  - While reset is low, every enable and flush is forced to 0.
- Default in RUN with no event: all enables 1, flushes 0.
- Register load rule: en=0 holds the register. flush=1 is only meaningful with en=1. if_id_en=0 overrides if_id_flush.
- Load-use detection (sub-module): lu = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- Priority per cycle: dmem_busy > ex_redirect > lu > imem_busy.
  - dmem_busy (RUN/DRAIN): all enables 0 (full freeze); state and drain counter hold.
  - ex_redirect: pc_en=1 (loads target), if_id_flush=1, id_ex_flush=1; flush_cnt+1. The instruction in EX itself proceeds.
  - lu: pc_en=0, if_id_en=0, id_ex_flush=1, one cycle only; stall_cnt+1.
  - imem_busy: pc_en=0, if_id_flush=1 (bubble into ID), rest advance; stall_cnt+1.
- Counters saturate at all-ones.
- FSM:
  - RUN: cs_req & !dmem_busy -> DRAIN, drain counter cleared.
  - DRAIN: fetch stopped (pc_en=0, if_id_flush=1). A redirect still sets pc_en=1 so the resume PC is correct.
    - Drain counter increments on cycles with no dmem_busy and no lu.
    - At counter==DRAIN_CYCLES-1 on an advancing cycle -> SWITCH.
    - cs_req low -> RUN (abort, counter cleared).
  - SWITCH: all enables 0; cs_ack=1 (registered, set on entry). cs_done -> RUN; cs_ack=0 the following cycle.
  - States 3..7 are illegal and return to RUN.
- Simultaneous cases:
  - cs_req with lu/redirect in RUN: the hazard action applies and DRAIN is entered the same edge.
  - cs_done outside SWITCH is ignored.
- Reset mid-DRAIN/SWITCH: immediate return to RUN with cs_ack=0. The requester must re-issue cs_req.

Decomposition:
- Package pipeline_ctrl_pkg: state encoding (RUN=0, DRAIN=1, SWITCH=2), REG_ADDR_W, x0 constant.
- Sub-module load_use_detect: purely combinational comparator producing lu.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID add reads rs1=5 -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1, stall_cnt=1; next cycle all en=1.
- Load with ex_rd=0, id_rs1=0 -> no stall, counters stay 0.
- ex_redirect=1 together with lu -> pc_en=1, if_id_flush=1, id_ex_flush=1, flush_cnt=1, stall_cnt=0.
- dmem_busy held 3 cycles during lu -> all en=0 for 3 cycles, then lu stall 1 cycle.
- cs_req in RUN, DRAIN_CYCLES=4, dmem_busy in 2nd DRAIN cycle -> cs_ack rises after 5 DRAIN cycles; cs_done pulse -> RUN, cs_ack=0 next cycle.
- Reset low during SWITCH -> cs_ack=0, state_o=0 immediately (asynchronous); cs_req dropped mid-DRAIN -> RUN next edge.
